// File: rtl/wb_master_arbiter.sv
`default_nettype none
// ==========================================================================
// Module   : wb_master_arbiter
// Function : round-robin NCH:1 Wishbone master arbiter; optional watchdog
//            included when WB_ARB_TIMEOUT_EN is defined.
// Revision : 1.0
// ==========================================================================
module wb_master_arbiter #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          m_cyc_i,
  input  logic [NCH-1:0]          m_stb_i,
  input  logic [NCH-1:0]          m_we_i,
  input  logic [NCH*AW-1:0]       m_adr_i,
  input  logic [NCH*(DW/8)-1:0]   m_sel_i,
  input  logic [NCH*DW-1:0]       m_dat_i,
  input  logic [NCH*3-1:0]        m_cti_i,
  input  logic [NCH*2-1:0]        m_bte_i,
  output logic [NCH-1:0]          m_ack_o,
  output logic [NCH-1:0]          m_err_o,
  output logic [NCH-1:0]          m_rty_o,
  output logic [DW-1:0]           m_dat_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [AW-1:0]           s_adr_o,
  output logic [(DW/8)-1:0]       s_sel_o,
  output logic [DW-1:0]           s_dat_o,
  output logic [2:0]              s_cti_o,
  output logic [1:0]              s_bte_o,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_rty_i,
  input  logic [DW-1:0]           s_dat_i,
  output logic [NCH-1:0]          gnt_o,
  output logic                    tmo_o
);

  localparam int SW = DW / 8;
  localparam int OW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [OW:0] c_nch = (OW+1)'(NCH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [OW-1:0] r_owner, w_owner_nxt;
  logic [OW-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [OW-1:0] w_pick;
  logic          w_found;
  logic          w_owner_cyc;
  logic          w_term;
  logic          w_tmo;
  logic          w_live;

  function automatic logic [OW-1:0] f_add_mod(input logic [OW-1:0] a, input logic [OW-1:0] b);
    logic [OW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= c_nch) s = s - c_nch;
    return s[OW-1:0];
  endfunction

  // First requester at or after the round-robin pointer, wrapping mod NCH.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    for (int i = 0; i < NCH; i++) begin
      if (!w_found && m_cyc_i[f_add_mod(r_rr_ptr, OW'(i))]) begin
        w_found = 1'b1;
        w_pick  = f_add_mod(r_rr_ptr, OW'(i));
      end
    end
  end

  assign w_owner_cyc = m_cyc_i[r_owner];
  assign w_term      = s_ack_i | s_err_i | s_rty_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] c_tmo = 16'(TMO);
  logic [15:0] r_wdt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             r_wdt <= '0;
    else if (r_state != ST_OWN || w_term) r_wdt <= '0;
    else if (s_stb_o)                     r_wdt <= r_wdt + 16'd1;
  end

  assign w_tmo = (r_state == ST_OWN) && (r_wdt == c_tmo);
`else
  assign w_tmo = 1'b0;
`endif

  assign tmo_o  = w_tmo;
  assign w_live = (r_state == ST_OWN) && !w_tmo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // A release always wins over a same-cycle watchdog expiry.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_OWN;
          w_owner_nxt = w_pick;
        end
      end
      ST_OWN: begin
        if (!w_owner_cyc) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = f_add_mod(r_owner, OW'(1));
        end else if (w_tmo) begin
          w_state_nxt = ST_ABORT;
        end
      end
      ST_ABORT: begin
        if (!w_owner_cyc) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = f_add_mod(r_owner, OW'(1));
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign s_cyc_o = w_live & w_owner_cyc;
  assign s_stb_o = w_live & w_owner_cyc & m_stb_i[r_owner];
  assign s_we_o  = m_we_i[r_owner];
  assign s_adr_o = m_adr_i[r_owner*AW +: AW];
  assign s_sel_o = m_sel_i[r_owner*SW +: SW];
  assign s_dat_o = m_dat_i[r_owner*DW +: DW];
  assign s_cti_o = m_cti_i[r_owner*3 +: 3];
  assign s_bte_o = m_bte_i[r_owner*2 +: 2];
  assign m_dat_o = s_dat_i;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic w_sel;
    assign w_sel      = (r_owner == OW'(k));
    assign gnt_o[k]   = (r_state != ST_IDLE) && w_sel;
    assign m_ack_o[k] = w_live && w_sel && s_ack_i;
    assign m_err_o[k] = w_sel && ((w_live && s_err_i) || w_tmo);
    assign m_rty_o[k] = w_live && w_sel && s_rty_i;
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_master_arbiter.sv
`default_nettype none
// ==========================================================================
// Module   : tb_wb_master_arbiter
// Function : directed plus randomized bench against a cycle-level bus model.
// Revision : 1.0
// ==========================================================================
module tb_wb_master_arbiter;

  localparam int NCH = 4;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int SW  = DW / 8;
  localparam int TMO = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NCH-1:0]      m_cyc_i, m_stb_i, m_we_i;
  logic [NCH*AW-1:0]   m_adr_i;
  logic [NCH*SW-1:0]   m_sel_i;
  logic [NCH*DW-1:0]   m_dat_i;
  logic [NCH*3-1:0]    m_cti_i;
  logic [NCH*2-1:0]    m_bte_i;
  logic [NCH-1:0]      m_ack_o, m_err_o, m_rty_o;
  logic [DW-1:0]       m_dat_o;
  logic                s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]       s_adr_o;
  logic [SW-1:0]       s_sel_o;
  logic [DW-1:0]       s_dat_o;
  logic [2:0]          s_cti_o;
  logic [1:0]          s_bte_o;
  logic                s_ack_i, s_err_i, s_rty_i;
  logic [DW-1:0]       s_dat_i;
  logic [NCH-1:0]      gnt_o;
  logic                tmo_o;

  wb_master_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .TMO(TMO)) u_dut (
    .clk(clk), .rst(rst),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i),
    .m_sel_i(m_sel_i), .m_dat_i(m_dat_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_dat_i(s_dat_i),
    .gnt_o(gnt_o), .tmo_o(tmo_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Bus model: who owns the bus (-1 when free), where the next search starts,
  // how many stalled strobe cycles the owner has accumulated, and whether the
  // owner has been cut off by the watchdog.
  int mdl_owner = -1;
  int mdl_ptr   = 0;
  int mdl_stall = 0;
  bit mdl_abort = 1'b0;

  task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void mdl_reset();
    mdl_owner = -1;
    mdl_ptr   = 0;
    mdl_stall = 0;
    mdl_abort = 1'b0;
  endfunction

  function automatic bit mdl_fire();
    bit f;
    f = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
    f = (mdl_owner >= 0) && !mdl_abort && (mdl_stall == TMO);
`endif
    return f;
  endfunction

  function automatic int mdl_pick();
    for (int i = 0; i < NCH; i++) begin
      if (m_cyc_i[(mdl_ptr + i) % NCH]) return (mdl_ptr + i) % NCH;
    end
    return -1;
  endfunction

  task automatic check_model();
    logic [NCH-1:0] e_gnt, e_ack, e_err, e_rty;
    logic           e_cyc, e_stb;
    bit             fire, live;
    int             o;
    o     = mdl_owner;
    fire  = mdl_fire();
    live  = (o >= 0) && !mdl_abort && !fire;
    e_gnt = '0; e_ack = '0; e_err = '0; e_rty = '0;
    e_cyc = 1'b0; e_stb = 1'b0;
    if (o >= 0) e_gnt[o] = 1'b1;
    if (live) begin
      e_cyc    = m_cyc_i[o];
      e_stb    = m_cyc_i[o] & m_stb_i[o];
      e_ack[o] = s_ack_i;
      e_err[o] = s_err_i;
      e_rty[o] = s_rty_i;
    end
    if (fire) e_err[o] = 1'b1;
    check_val("mdl_gnt", gnt_o, e_gnt);
    check_val("mdl_cyc", s_cyc_o, e_cyc);
    check_val("mdl_stb", s_stb_o, e_stb);
    check_val("mdl_ack", m_ack_o, e_ack);
    check_val("mdl_err", m_err_o, e_err);
    check_val("mdl_rty", m_rty_o, e_rty);
    check_val("mdl_tmo", tmo_o, fire);
    check_val("mdl_rdat", m_dat_o, s_dat_i);
    if (live && m_cyc_i[o]) begin
      check_val("mdl_adr", s_adr_o, m_adr_i[o*AW +: AW]);
      check_val("mdl_we",  s_we_o,  m_we_i[o]);
      check_val("mdl_wdat", s_dat_o, m_dat_i[o*DW +: DW]);
      check_val("mdl_sel", s_sel_o, m_sel_i[o*SW +: SW]);
      check_val("mdl_cti", s_cti_o, m_cti_i[o*3 +: 3]);
      check_val("mdl_bte", s_bte_o, m_bte_i[o*2 +: 2]);
    end
  endtask

  function automatic void mdl_update();
    bit fire;
    fire = mdl_fire();
    if (!rst) begin
      mdl_reset();
    end else if (mdl_owner < 0) begin
      mdl_stall = 0;
      mdl_owner = mdl_pick();
      mdl_abort = 1'b0;
    end else if (!m_cyc_i[mdl_owner]) begin
      mdl_ptr   = (mdl_owner + 1) % NCH;
      mdl_owner = -1;
      mdl_abort = 1'b0;
      mdl_stall = 0;
    end else if (fire) begin
      mdl_abort = 1'b1;
      mdl_stall = 0;
    end else if (!mdl_abort) begin
      if (s_ack_i || s_err_i || s_rty_i) mdl_stall = 0;
      else if (m_stb_i[mdl_owner])       mdl_stall++;
    end
  endfunction

  // Check at the falling edge, advance the model at the rising edge.
  task automatic tick();
    @(negedge clk);
    check_model();
    @(posedge clk);
    mdl_update();
    #1;
  endtask

  task automatic wait_gnt(string tag, logic [NCH-1:0] exp);
    int n;
    n = 0;
    while (gnt_o == '0 && n < 8) begin
      tick();
      n++;
    end
    check_val(tag, gnt_o, exp);
  endtask

  task automatic clear_inputs();
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_adr_i = '0; m_sel_i = '0; m_dat_i = '0; m_cti_i = '0; m_bte_i = '0;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0; s_dat_i = '0;
  endtask

  task automatic drive_random();
    for (int k = 0; k < NCH; k++) begin
      if (m_cyc_i[k]) begin
        if ($urandom_range(5) == 0) m_cyc_i[k] = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        m_cyc_i[k] = 1'b1;
      end
      m_stb_i[k] = 1'($urandom_range(1));
      m_we_i[k]  = 1'($urandom_range(1));
    end
    m_adr_i = (NCH*AW)'({$urandom(), $urandom()});
    m_dat_i = (NCH*DW)'({$urandom(), $urandom()});
    m_sel_i = (NCH*SW)'($urandom());
    m_cti_i = (NCH*3)'($urandom());
    m_bte_i = (NCH*2)'($urandom());
    s_ack_i = ($urandom_range(3) == 0);
    s_err_i = ($urandom_range(3) == 0);
    s_rty_i = ($urandom_range(3) == 0);
    s_dat_i = DW'($urandom());
  endtask

  logic [2:0] cti_seq [4] = '{3'b010, 3'b010, 3'b010, 3'b111};
  logic [3:0] rr_exp  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    clear_inputs();
    #2 rst = 1'b0;
    mdl_reset();
    #1;
    check_val("rst_gnt", gnt_o, 4'b0000);
    check_val("rst_cyc", s_cyc_o, 1'b0);
    check_val("rst_tmo", tmo_o, 1'b0);
    tick(); tick();
    rst = 1'b1;

    // Two requesters after reset; channel 0 wins, channel 1 two cycles after release.
    m_cyc_i = 4'b0011; m_stb_i = 4'b0011;
    tick();
    check_val("tie_gnt0", gnt_o, 4'b0001);
    m_cyc_i = 4'b0010;
    tick();
    check_val("rel_idle", gnt_o, 4'b0000);
    tick();
    check_val("tie_gnt1", gnt_o, 4'b0010);
    m_cyc_i = '0;
    tick(); tick();

    // Channel 1 burst while channel 3 waits.
    m_cyc_i = 4'b0010; m_stb_i = 4'b0010;
    wait_gnt("burst_gnt", 4'b0010);
    m_cyc_i[3] = 1'b1; m_stb_i[3] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      m_cti_i[3 +: 3] = cti_seq[b];
      s_ack_i = 1'b1;
      #1;
      check_val("burst_ack", m_ack_o, 4'b0010);
      check_val("burst_cti", s_cti_o, cti_seq[b]);
      check_val("burst_hold", gnt_o, 4'b0010);
      tick();
    end
    s_ack_i = 1'b0; m_cyc_i[1] = 1'b0; m_stb_i[1] = 1'b0;
    tick();
    check_val("burst_idle", gnt_o, 4'b0000);
    tick();
    check_val("burst_next", gnt_o, 4'b1000);
    m_cyc_i = '0; m_stb_i = '0;
    tick(); tick();

    // Everybody requests; each owner leaves after one ack.
    m_cyc_i = '1; m_stb_i = '1;
    for (int n = 0; n < 5; n++) begin
      wait_gnt("rr_order", rr_exp[n]);
      s_ack_i = 1'b1;
      #1;
      check_val("rr_ack", m_ack_o, rr_exp[n]);
      tick();
      s_ack_i = 1'b0;
      m_cyc_i = m_cyc_i & ~gnt_o;
      tick();
      m_cyc_i = '1;
    end
    m_cyc_i = '0; m_stb_i = '0;
    tick(); tick();

    // Error termination on a channel 0 write.
    m_cyc_i = 4'b0001; m_stb_i = 4'b0001; m_we_i = 4'b0001;
    wait_gnt("err_gnt", 4'b0001);
    s_err_i = 1'b1;
    #1;
    check_val("err_err", m_err_o, 4'b0001);
    check_val("err_ack", m_ack_o, 4'b0000);
    tick();
    s_err_i = 1'b0;
    tick();
    check_val("err_hold", gnt_o, 4'b0001);
    check_val("err_cyc", s_cyc_o, 1'b1);
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    tick(); tick();

    // Slave never answers channel 1.
    m_cyc_i = 4'b0010; m_stb_i = 4'b0010;
    wait_gnt("wdt_gnt", 4'b0010);
    m_cyc_i[0] = 1'b1;
    for (int i = 0; i < TMO; i++) begin
      check_val("wdt_quiet", tmo_o, 1'b0);
      tick();
    end
`ifdef WB_ARB_TIMEOUT_EN
    check_val("wdt_tmo", tmo_o, 1'b1);
    check_val("wdt_err", m_err_o, 4'b0010);
    check_val("wdt_cyc", s_cyc_o, 1'b0);
    tick();
    check_val("abort_tmo", tmo_o, 1'b0);
    check_val("abort_cyc", s_cyc_o, 1'b0);
    check_val("abort_gnt", gnt_o, 4'b0010);
`else
    check_val("nowdt_tmo", tmo_o, 1'b0);
    check_val("nowdt_err", m_err_o, 4'b0000);
    check_val("nowdt_cyc", s_cyc_o, 1'b1);
    tick();
`endif
    m_cyc_i[1] = 1'b0;
    tick();
    check_val("wdt_idle", gnt_o, 4'b0000);
    tick();
    check_val("wdt_next", gnt_o, 4'b0001);
    m_cyc_i = '0; m_stb_i = '0;
    tick(); tick();

    for (int c = 0; c < 2000; c++) begin
      drive_random();
      tick();
    end

    // Reset in the middle of a channel 2 burst, between clock edges.
    clear_inputs();
    tick(); tick(); tick();
    m_cyc_i = 4'b0100; m_stb_i = 4'b0100; m_cti_i[6 +: 3] = 3'b010;
    wait_gnt("mid_gnt", 4'b0100);
    tick();
    check_val("mid_cyc", s_cyc_o, 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    mdl_reset();
    #1;
    check_val("arst_cyc", s_cyc_o, 1'b0);
    check_val("arst_stb", s_stb_o, 1'b0);
    check_val("arst_gnt", gnt_o, 4'b0000);
    m_cyc_i = '1; m_stb_i = '1;
    tick(); tick();
    rst = 1'b1;
    tick();
    check_val("arst_fresh", gnt_o, 4'b0001);
    m_cyc_i = '0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL sim_timeout: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
